// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage around the PC register.
// Presents the PC to a one-cycle-latency instruction memory, tracks the fetch
// in flight, and queues returned {pc, inst} pairs in a small FIFO for decode.
// A redirect flushes the FIFO and the in-flight fetch and reloads the PC.
//
// Decode handshake: the head entry is transferred on a rising edge where
// id_valid=1 and id_ready=1. While id_valid=1 and id_ready=0 the head
// (id_pc, id_inst) holds stable. id_valid never depends on id_ready.
module fetch_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_inst,
  output logic [WIDTH-1:0] id_pc
);

  localparam int PW = $clog2(DEPTH);
  // Occupancy arithmetic width: wide enough that count+inflight-pop never wraps.
  localparam int CW = $clog2(DEPTH) + 2;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [WIDTH-1:0] fifo_pc_q   [DEPTH];
  logic [WIDTH-1:0] fifo_inst_q [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW-1:0] occ;

  assign imem_addr = pc;
  assign id_valid  = (count_q != '0);
  assign id_pc     = fifo_pc_q[rd_ptr_q];
  assign id_inst   = fifo_inst_q[rd_ptr_q];

  // Handshake decode, issue decision and PC register control.
  always_comb begin
    pop     = id_valid & id_ready;
    // Entries that will occupy the FIFO after this edge if nothing new issues.
    occ     = CW'(count_q) + CW'(inflight_q) - CW'(pop);
    issue   = !rst && !redirect && (occ < CW'(DEPTH));
    push    = inflight_q && !redirect;
    pc_en   = 1'b0;
    pc_next = pc + WIDTH'(4);
    if (rst) begin
      pc_en = 1'b0;
    end else if (redirect) begin
      pc_en   = 1'b1;
      pc_next = redirect_pc;
    end else if (issue) begin
      pc_en = 1'b1;
    end
  end

  // Next-state for pointers, occupancy and the in-flight tracker.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc : inflight_pc_q;
    if (redirect) begin
      // Flush: drop queued entries, the returning response and any pop.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // FIFO storage; contents are don't-care while not counted, so no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // The issue rule reserves a slot for every fetch, so a full FIFO never sees a push.
  push_into_full_a: assert property (@(posedge clk) disable iff (rst)
    push |-> (count_q != (PW+1)'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a PC register and a
// synchronous instruction memory modelled around it. The reference model is
// the program-order stream decode should see: consecutive word addresses
// starting at the last reset (0x0) or redirect target.
module tb_fetch_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pc = '0;
  logic         pc_en;
  logic [W-1:0] pc_next;
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_rdata = '0;
  logic         redirect = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         id_valid;
  logic         id_ready = 1'b0;
  logic [W-1:0] id_inst;
  logic [W-1:0] id_pc;

  int checks = 0;
  int errors = 0;
  int since_flush = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_e;

  // clock / reset
  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(W), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_en      (pc_en),
    .pc_next    (pc_next),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc)
  );

  // Memory contents: a fixed scramble of the address.
  function automatic logic [W-1:0] inst_of(input logic [W-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // PC register (reset value 0) and one-cycle-latency instruction memory.
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (pc_en) pc <= pc_next;
    imem_rdata <= inst_of(imem_addr);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Restart the expected stream at a new program-order origin.
  task automatic flush_model(input logic [W-1:0] target);
    exp_q.delete();
    for (int i = 0; i < 4; i++)
      exp_q.push_back({target + W'(4 * i), inst_of(target + W'(4 * i))});
  endtask

  // driver: one cycle of stimulus, returning at the following falling edge
  task automatic step(input logic r, input logic rd, input logic rdy, input logic [W-1:0] tgt);
    @(posedge clk);
    #1;
    rst         = r;
    redirect    = rd;
    redirect_pc = tgt;
    id_ready    = rdy;
    if (r) flush_model('0);
    else if (rd) flush_model(tgt);
    @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    check("imem_addr", imem_addr, pc);
    if (rst) begin
      check("pc_en_in_reset", W'(pc_en), W'(0));
    end else if (redirect) begin
      check("pc_en_redirect", W'(pc_en), W'(1));
      check("pc_next_redirect", pc_next, redirect_pc);
    end else if (pc_en) begin
      check("pc_next_seq", pc_next, pc + W'(4));
    end

    if (rst || redirect) begin
      since_flush = 0;
    end else begin
      if (since_flush < 1000) since_flush++;
      // Target fetched one cycle after the flush, visible two cycles after that,
      // and the stream never bubbles afterwards.
      if (since_flush <= 2) check("id_valid_after_flush", W'(id_valid), W'(0));
      else check("id_valid_steady", W'(id_valid), W'(1));
    end

    if (!rst && !redirect && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h, expected no entry", id_pc);
      end else begin
        exp_e = exp_q.pop_front();
        check("id_pc", id_pc, exp_e[2*W-1:W]);
        check("id_inst", id_inst, exp_e[W-1:0]);
        exp_q.push_back({exp_e[2*W-1:W] + W'(16), inst_of(exp_e[2*W-1:W] + W'(16))});
      end
    end
  end

  // stimulus sequence
  initial begin
    logic         r, rd, rdy;
    logic [W-1:0] tgt;
    flush_model('0);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    check("reset_id_valid", W'(id_valid), W'(0));
    check("reset_pc_en", W'(pc_en), W'(0));

    // Backpressure from release: two entries held, PC parked at 0x8.
    repeat (8) step(1'b0, 1'b0, 1'b0, '0);
    check("bp_pc", pc, 32'h8);
    check("bp_pc_en", W'(pc_en), W'(0));
    check("bp_id_valid", W'(id_valid), W'(1));
    check("bp_id_pc", id_pc, 32'h0);
    check("bp_id_inst", id_inst, inst_of(32'h0));

    // Drain 0x0, 0x4, then 0x8 with no gap.
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    // Redirect to 0x100 with the FIFO full.
    repeat (6) step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    // Redirect during a streaming push with id_ready=1.
    step(1'b0, 1'b1, 1'b1, 32'h200);
    repeat (5) step(1'b0, 1'b0, 1'b1, '0);

    // Back-to-back redirects: the last target wins.
    step(1'b0, 1'b1, 1'b0, 32'h300);
    step(1'b0, 1'b1, 1'b1, 32'h400);
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    // Address wrap at the top of memory.
    step(1'b0, 1'b1, 1'b1, 32'hFFFFFFF8);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("wrap_pc", pc, 32'hFFFFFFFC);
    check("wrap_pc_en", W'(pc_en), W'(1));
    check("wrap_pc_next", pc_next, 32'h0);
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    // One-cycle reset with two entries queued.
    repeat (5) step(1'b0, 1'b0, 1'b0, '0);
    check("pre_rst_id_valid", W'(id_valid), W'(1));
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("post_rst_id_valid", W'(id_valid), W'(0));
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      rd  = !r && ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF0 + W'(4 * $urandom_range(0, 3));
      else tgt = $urandom() & 32'hFFFFFFFC;
      step(r, rd, rdy, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
